// File: rtl/apb_slave_mem_pkg.sv
// Shared constants, FSM state encodings and address-check helper for the APB memory responder.
package apb_slave_mem_pkg;

  localparam int unsigned WAIT_CFG_WIDTH = 4;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACCESS = 1'b1;

  // Misaligned, below the window, or past the last word.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] depth);
    logic [63:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_wait_ctr.sv
// Loadable wait-state down-counter; done is a registered flag that rises as the count reaches zero.
module apb_slave_wait_ctr
  import apb_slave_mem_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [WAIT_CFG_WIDTH-1:0] load_val_i,
  input  logic                      dec_i,
  input  logic                      clr_i,
  output logic [WAIT_CFG_WIDTH-1:0] cnt_o,
  output logic                      done_o
);

  logic [WAIT_CFG_WIDTH-1:0] cnt_q, cnt_d;
  logic                      done_q, done_d;

  // Clear wins over load, load over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (load_i) begin
      cnt_d  = load_val_i;
      done_d = (load_val_i == '0);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d  = cnt_q - WAIT_CFG_WIDTH'(1);
      done_d = (cnt_q == WAIT_CFG_WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/apb_slave_mem_responder.sv
// APB slave responder backed by a word-addressed register memory with programmable wait states.
// Define APB_SLAVE_MEM_RESPONDER_PROTOCOL_CHECK_EN to add the sticky prot_err protocol monitor.
module apb_slave_mem_responder
  import apb_slave_mem_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH  = 32,
  parameter int unsigned PWDATA_WIDTH = 32,
  parameter int unsigned PRDATA_WIDTH = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic                      pclock,
  input  logic                      preset,
  input  logic [PADDR_WIDTH-1:0]    paddr,
  input  logic                      prwd,
  input  logic [PWDATA_WIDTH-1:0]   pwdata,
  input  logic                      psel,
  input  logic                      penable,
  input  logic [WAIT_CFG_WIDTH-1:0] wait_cfg,
  output logic [PRDATA_WIDTH-1:0]   prdata,
  output logic                      pready,
  output logic                      pslverr
`ifdef APB_SLAVE_MEM_RESPONDER_PROTOCOL_CHECK_EN
  ,
  output logic                      prot_err
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                    state_q, state_d;
  logic                      is_write_q, is_write_d;
  logic                      err_q, err_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [PRDATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                      pslverr_q, pslverr_d;
  logic [PRDATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                      setup_c;
  logic [IDX_W-1:0]          idx_now_c;
  logic                      err_now_c;
  logic                      ctr_load_c, ctr_dec_c, ctr_clr_c;
  logic                      commit_c;
  logic                      rise_c, rise_err_c, rise_write_c;
  logic [IDX_W-1:0]          rise_idx_c;
  logic [WAIT_CFG_WIDTH-1:0] ctr_cnt;
  logic                      ctr_done;

  assign setup_c   = psel && !penable;
  assign idx_now_c = IDX_W'((paddr - PADDR_WIDTH'(BASE_ADDR)) >> 2);
  assign err_now_c = addr_err(64'(paddr), 64'(BASE_ADDR), 64'(DEPTH));

  apb_slave_wait_ctr u_wait_ctr (
    .clk_i      (pclock),
    .rst_i      (preset),
    .load_i     (ctr_load_c),
    .load_val_i (wait_cfg),
    .dec_i      (ctr_dec_c),
    .clr_i      (ctr_clr_c),
    .cnt_o      (ctr_cnt),
    .done_o     (ctr_done)
  );

  // Next-state, transfer capture and response generation.
  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    err_d        = err_q;
    idx_d        = idx_q;
    prdata_d     = prdata_q;
    pslverr_d    = pslverr_q;
    ctr_load_c   = 1'b0;
    ctr_dec_c    = 1'b0;
    ctr_clr_c    = 1'b0;
    commit_c     = 1'b0;
    rise_c       = 1'b0;
    rise_err_c   = err_q;
    rise_write_c = is_write_q;
    rise_idx_c   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (setup_c) begin
          state_d      = ST_ACCESS;
          is_write_d   = prwd;
          err_d        = err_now_c;
          idx_d        = idx_now_c;
          ctr_load_c   = 1'b1;
          rise_c       = (wait_cfg == '0);
          rise_err_c   = err_now_c;
          rise_write_c = prwd;
          rise_idx_c   = idx_now_c;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d   = ST_IDLE;
          ctr_clr_c = 1'b1;
          prdata_d  = '0;
          pslverr_d = 1'b0;
        end else if (ctr_done) begin
          if (penable) begin
            state_d   = ST_IDLE;
            commit_c  = is_write_q && !err_q;
            ctr_clr_c = 1'b1;
            prdata_d  = '0;
            pslverr_d = 1'b0;
          end
        end else begin
          ctr_dec_c = 1'b1;
          rise_c    = (ctr_cnt == WAIT_CFG_WIDTH'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Response fields are loaded on the same edge that raises pready.
    if (rise_c) begin
      pslverr_d = rise_err_c;
      prdata_d  = (!rise_write_c && !rise_err_c) ? mem_q[rise_idx_c] : '0;
    end
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      is_write_q <= is_write_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      if (commit_c) begin
        mem_q[idx_q] <= PRDATA_WIDTH'(pwdata);
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = ctr_done;
  assign pslverr = pslverr_q;

`ifdef APB_SLAVE_MEM_RESPONDER_PROTOCOL_CHECK_EN
  logic [PADDR_WIDTH-1:0]  paddr_q;
  logic [PWDATA_WIDTH-1:0] pwdata_q;
  logic                    prot_err_q;
  logic                    prot_viol_c;

  // Any strobe misuse or bus instability during a selected access phase.
  always_comb begin
    prot_viol_c = 1'b0;
    if (penable && !psel) begin
      prot_viol_c = 1'b1;
    end
    if ((state_q == ST_IDLE) && psel && penable) begin
      prot_viol_c = 1'b1;
    end
    if ((state_q == ST_ACCESS) && psel) begin
      if ((paddr != paddr_q) || (prwd != is_write_q) || (pwdata != pwdata_q)) begin
        prot_viol_c = 1'b1;
      end
      if (!penable) begin
        prot_viol_c = 1'b1;
      end
    end
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      prot_err_q <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      if (prot_viol_c) begin
        prot_err_q <= 1'b1;
      end
      if ((state_q == ST_IDLE) && setup_c) begin
        paddr_q  <= paddr;
        pwdata_q <= pwdata;
      end
    end
  end

  assign prot_err = prot_err_q;
`endif

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// Directed self-checking bench: transaction-level model plus per-cycle output compare.
module tb_apb_slave_mem_responder;

  localparam longint BASE  = 0;
  localparam longint DEPTH = 16;

  logic        pclock;
  logic        preset;
  logic [31:0] paddr;
  logic        prwd;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [3:0]  wait_cfg;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_slave_mem_responder dut (
    .pclock   (pclock),
    .preset   (preset),
    .paddr    (paddr),
    .prwd     (prwd),
    .pwdata   (pwdata),
    .psel     (psel),
    .penable  (penable),
    .wait_cfg (wait_cfg),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: memory array plus progress through the current transfer.
  logic [31:0] m_mem [16];
  bit          m_active = 1'b0;
  int          m_acc = 0;
  int          m_wait = 0;
  logic [31:0] m_addr = '0;
  bit          m_write = 1'b0;
  bit          exp_pready = 1'b0;
  bit          exp_pslverr = 1'b0;
  logic [31:0] exp_prdata = '0;

  function automatic bit m_err(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return ((la % 4) != 0) || (la < BASE) || (((la - BASE) / 4) >= DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - BASE) / 4);
  endfunction

  always @(posedge pclock) begin
    if (preset) begin
      m_active = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (!m_active) begin
      if (psel && !penable) begin
        m_active = 1'b1;
        m_addr   = paddr;
        m_write  = prwd;
        m_wait   = int'(wait_cfg);
        m_acc    = 1;
      end
    end else if (!psel) begin
      m_active = 1'b0;
    end else if (exp_pready) begin
      if (penable) begin
        if (m_write && !m_err(m_addr)) m_mem[m_idx(m_addr)] = pwdata;
        m_active = 1'b0;
      end
    end else begin
      m_acc++;
    end
    exp_pready  = m_active && (m_acc >= m_wait + 1);
    exp_pslverr = exp_pready && m_err(m_addr);
    exp_prdata  = (exp_pready && !m_write && !m_err(m_addr)) ? m_mem[m_idx(m_addr)] : 32'h0;
  end

  always @(negedge pclock) begin
    if (chk_en) begin
      chk("cyc_pready", 32'(pready), 32'(exp_pready));
      chk("cyc_pslverr", 32'(pslverr), 32'(exp_pslverr));
      chk("cyc_prdata", prdata, exp_prdata);
    end
  end

  // One transfer; returns at the negedge where pready is seen, bus still in access phase.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] w, output logic [31:0] rd, output logic er,
                      output int cyc);
    @(negedge pclock);
    psel = 1'b1; penable = 1'b0; paddr = addr; prwd = wr; pwdata = data; wait_cfg = w;
    @(negedge pclock);
    penable = 1'b1;
    cyc = 1;
    while (!pready && cyc < 40) begin
      @(negedge pclock);
      cyc++;
    end
    if (!pready) begin
      n_chk++;
      n_err++;
      $display("FAIL xfer_timeout: addr %h got no pready expected pready within 40 cycles", addr);
    end
    rd = prdata;
    er = pslverr;
  endtask

  task automatic idle();
    @(negedge pclock);
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; prwd = 1'b0;
    pwdata = '0; wait_cfg = '0;
    repeat (2) @(negedge pclock);
    chk_en = 1'b1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    preset = 1'b0;

    xfer(1'b0, 32'h8, 32'h0, 4'd0, rd, er, cyc);
    chk("rd8_cycles", 32'(cyc), 32'd1);
    chk("rd8_data", rd, 32'h0);
    chk("rd8_err", 32'(er), 32'h0);
    idle();

    xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'd3, rd, er, cyc);
    chk("wr4_cycles", 32'(cyc), 32'd4);
    chk("wr4_err", 32'(er), 32'h0);
    idle();
    xfer(1'b0, 32'h4, 32'h0, 4'd1, rd, er, cyc);
    chk("rd4_cycles", 32'(cyc), 32'd2);
    chk("rd4_data", rd, 32'hDEADBEEF);
    idle();

    xfer(1'b1, 32'h40, 32'hCAFEF00D, 4'd0, rd, er, cyc);
    chk("wr40_err", 32'(er), 32'h1);
    chk("wr40_data", rd, 32'h0);
    idle();
    xfer(1'b0, 32'h6, 32'h0, 4'd2, rd, er, cyc);
    chk("rd6_err", 32'(er), 32'h1);
    chk("rd6_data", rd, 32'h0);
    chk("rd6_cycles", 32'(cyc), 32'd3);
    idle();
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 32'(i * 4), 32'h0, 4'd0, rd, er, cyc);
      chk($sformatf("sweep_%0d", i), rd, (i == 1) ? 32'hDEADBEEF : 32'h0);
    end
    idle();

    xfer(1'b1, 32'h0, 32'h1, 4'd0, rd, er, cyc);
    chk("b2b_wr_cycles", 32'(cyc), 32'd1);
    xfer(1'b0, 32'h0, 32'h0, 4'd0, rd, er, cyc);
    chk("b2b_rd_cycles", 32'(cyc), 32'd1);
    chk("b2b_rd_data", rd, 32'h1);
    idle();

    // psel=1/penable=1 with no setup must not start a transfer.
    @(negedge pclock);
    psel = 1'b1; penable = 1'b1; paddr = 32'h0; prwd = 1'b0;
    @(negedge pclock);
    chk("nosetup_pready", 32'(pready), 32'h0);
    psel = 1'b0; penable = 1'b0;

    xfer(1'b1, 32'hC, 32'h12345678, 4'd0, rd, er, cyc);
    idle();
    @(negedge pclock);
    psel = 1'b1; penable = 1'b0; paddr = 32'hC; prwd = 1'b1; pwdata = 32'hAAAA5555; wait_cfg = 4'd5;
    @(negedge pclock);
    penable = 1'b1;
    @(negedge pclock);
    psel = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge pclock);
      chk("abort_pready", 32'(pready), 32'h0);
    end
    xfer(1'b0, 32'hC, 32'h0, 4'd0, rd, er, cyc);
    chk("abort_rdC", rd, 32'h12345678);
    idle();

    @(negedge pclock);
    psel = 1'b1; penable = 1'b0; paddr = 32'h10; prwd = 1'b1; pwdata = 32'hFFFF0000; wait_cfg = 4'd2;
    @(negedge pclock);
    penable = 1'b1;
    @(negedge pclock);
    preset = 1'b1;
    @(negedge pclock);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    chk("midrst_prdata", prdata, 32'h0);
    chk("midrst_pready", 32'(pready), 32'h0);
    chk("midrst_pslverr", 32'(pslverr), 32'h0);
    xfer(1'b0, 32'h10, 32'h0, 4'd0, rd, er, cyc);
    chk("midrst_rd10", rd, 32'h0);
    xfer(1'b0, 32'h4, 32'h0, 4'd0, rd, er, cyc);
    chk("midrst_rd4", rd, 32'h0);
    xfer(1'b1, 32'h10, 32'h55, 4'd1, rd, er, cyc);
    chk("post_wr_cycles", 32'(cyc), 32'd2);
    xfer(1'b0, 32'h10, 32'h0, 4'd2, rd, er, cyc);
    chk("post_rd_cycles", 32'(cyc), 32'd3);
    chk("post_rd_data", rd, 32'h55);
    idle();
    repeat (2) @(negedge pclock);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got stuck expected completion before 200000");
    $fatal(1);
  end

endmodule
